// File: rtl/uart_rx_buffered_pkg.sv
// rtl/uart_rx_buffered_pkg.sv - shared UART definitions: state encodings, frame constants, default divisor
//
// Used by uart_rx_buffered and intended for reuse by a future uart_tx.
//   ST_*                 receiver state encodings (ST_PARITY only reached with UART_RX_PARITY_EN)
//   DATA_BITS            data bits per frame
//   FRAME_BITS           start + data + stop bits per 8N1 frame
//   DEFAULT_CLKS_PER_BIT baud divisor for a 14 ns clock at a 2000 ns bit time
package uart_rx_buffered_pkg;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = DATA_BITS + 2;
    localparam int DEFAULT_CLKS_PER_BIT = 143;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// rtl/uart_rx_buffered_sync_fifo.sv - show-ahead synchronous FIFO (module sync_fifo)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (flushes contents and pointers)
//   push       write push_data this edge; ignored when full unless pop is also accepted
//   push_data  write data
//   pop        remove head entry this edge; ignored when empty
//   head       registered head entry (show-ahead)
//   full       DEPTH entries held
//   empty      no entries held
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is allowed when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver with mid-bit sampling and a valid/ready output FIFO
//
// Optional build macro: UART_RX_PARITY_EN (8E1 framing, adds PARITY_ERR output)
// Ports:
//   CLK         system clock
//   RST         synchronous active-high reset
//   RS_RX       asynchronous serial input, idle high
//   DATA        FIFO head byte, meaningful while VALID=1
//   VALID       FIFO non-empty
//   READY       consumer accepts DATA on VALID&&READY at a CLK edge
//   FRAME_ERR   one-cycle pulse: stop bit sampled low
//   OVERRUN     one-cycle pulse: byte completed into a full FIFO with no pop
//   PARITY_ERR  one-cycle pulse: even parity failed (UART_RX_PARITY_EN only)
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RS_RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FRAME_ERR,
`ifdef UART_RX_PARITY_EN
    output logic       PARITY_ERR,
`endif
    output logic       OVERRUN
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    rx_state_t      state;
    logic           rx_meta;
    logic           rx_s;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           expired;
    logic           parity_ok;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;

`ifdef UART_RX_PARITY_EN
    logic           par_bit;
    assign parity_ok = ~^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign expired = (cnt == '0);

    // Push happens on the stop-bit sample edge itself, so VALID follows one cycle later.
    assign push  = (state == ST_STOP) && expired && rx_s && parity_ok;
    assign pop   = VALID && READY;
    assign VALID = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head      (DATA),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            rx_meta   <= RS_RX;
            rx_s      <= rx_meta;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else if (!rx_s) begin
                        state   <= ST_DATA;
                        cnt     <= FULL_LOAD;
                        bit_idx <= '0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as a glitch.
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= FULL_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        par_bit <= rx_s;
                        cnt     <= FULL_LOAD;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_s) begin
                        // Return to IDLE at mid-stop so a back-to-back start edge is caught.
                        state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        PARITY_ERR <= !parity_ok;
`endif
                    end else begin
                        FRAME_ERR <= 1'b1;
                        state     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    // Held-low line: one FRAME_ERR only, wait for the line to recover.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       RS_RX = 1'b1;
    logic       READY = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
`endif

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RS_RX      (RS_RX),
        .DATA       (DATA),
        .VALID      (VALID),
        .READY      (READY),
        .FRAME_ERR  (FRAME_ERR),
`ifdef UART_RX_PARITY_EN
        .PARITY_ERR (PARITY_ERR),
`endif
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Monitor: event totals observed on the falling edge, away from the active edge.
    logic [7:0] got_q[$];
    int ferr_total  = 0;
    int ovr_total   = 0;
    int valid_total = 0;
    int perr_total  = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (VALID && READY) got_q.push_back(DATA);
            if (VALID)          valid_total++;
            if (FRAME_ERR)      ferr_total++;
            if (OVERRUN)        ovr_total++;
`ifdef UART_RX_PARITY_EN
            if (PARITY_ERR)     perr_total++;
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        RS_RX = b;
        tick(CPB);
    endtask

    // Builds the line waveform straight from the frame format: start, 8 data LSB first, [even parity], stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`else
        if (bad_par) RS_RX = 1'b1;
`endif
        drive_bit(stop_b);
    endtask

    task automatic chk_queue(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        int         hold_low;
        int         exp_bytes;
        int         exp_ferr;
        int         exp_valid_cycles;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] exp_q[$];
    int f0, v0, o0, p0, exp_ferr;
    logic rnd_on;

    initial begin
        tbl[0] = '{8'h0A, 1'b1,  0, 1, 0, 1};
        tbl[1] = '{8'h3C, 1'b0, 40, 0, 1, 0};
        tbl[2] = '{8'hA5, 1'b1,  0, 1, 0, 1};
        tbl[3] = '{8'h55, 1'b1,  0, 1, 0, 1};
        tbl[4] = '{8'hFF, 1'b0,  3, 0, 1, 0};
        tbl[5] = '{8'h00, 1'b1,  0, 1, 0, 1};

        // Reset state
        tick(5);
        chk("reset_valid", VALID, 0);
        chk("reset_data", DATA, 0);
        chk("reset_frame_err", FRAME_ERR, 0);
        chk("reset_overrun", OVERRUN, 0);
        RST = 1'b0;
        tick(3 * CPB);
        chk("idle_valid", VALID, 0);

        // Table-driven single frames (first row is the 0x0A frame)
        for (int i = 0; i < 6; i++) begin
            got_q.delete();
            f0 = ferr_total;
            v0 = valid_total;
            send_frame(tbl[i].data, tbl[i].stop_b, 1'b0);
            if (tbl[i].hold_low > 0) begin
                RS_RX = 1'b0;
                tick(tbl[i].hold_low);
            end
            RS_RX = 1'b1;
            tick(2 * CPB);
            chk($sformatf("vec%0d_frame_err", i), ferr_total - f0, tbl[i].exp_ferr);
            chk($sformatf("vec%0d_valid_cycles", i), valid_total - v0, tbl[i].exp_valid_cycles);
            chk($sformatf("vec%0d_bytes", i), got_q.size(), tbl[i].exp_bytes);
            if (tbl[i].exp_bytes == 1 && got_q.size() == 1)
                chk($sformatf("vec%0d_data", i), int'(got_q[0]), int'(tbl[i].data));
        end

        // Back-to-back frames with no idle gap
        got_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h0A, 1'b1, 1'b0);
        tick(2 * CPB);
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h0A};
        chk_queue("b2b", exp_q);

        // Short low glitch, then a real frame
        got_q.delete();
        f0 = ferr_total;
        v0 = valid_total;
        RS_RX = 1'b0;
        tick(4);
        RS_RX = 1'b1;
        tick(2 * CPB);
        chk("glitch_valid", valid_total - v0, 0);
        chk("glitch_frame_err", ferr_total - f0, 0);
        send_frame(8'h55, 1'b1, 1'b0);
        tick(2 * CPB);
        exp_q = '{8'h55};
        chk_queue("after_glitch", exp_q);

        // Overrun: fill with READY low, fifth byte dropped
        got_q.delete();
        READY = 1'b0;
        o0 = ovr_total;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0);
        tick(CPB);
        chk("overrun_pulses", ovr_total - o0, 1);
        chk("overrun_valid_held", VALID, 1);
        chk("overrun_no_pop", got_q.size(), 0);
        READY = 1'b1;
        tick(10);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_queue("drain", exp_q);
        chk("drain_empty", VALID, 0);

        // Reset mid-frame flushes FIFO and abandons the partial byte
        READY = 1'b0;
        got_q.delete();
        send_frame(8'h33, 1'b1, 1'b0);
        tick(CPB);
        chk("pre_reset_valid", VALID, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        RS_RX = 1'b1;
        tick(CPB / 2);
        RST = 1'b1;
        tick(1);
        chk("rst_valid", VALID, 0);
        chk("rst_data", DATA, 0);
        RST = 1'b0;
        tick(CPB / 2);
        for (int i = 4; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        READY = 1'b1;
        tick(2 * CPB);
        chk("rst_flushed", got_q.size(), 0);
        p0 = perr_total;
        send_frame(8'h81, 1'b1, 1'b1);
        tick(2 * CPB);
`ifdef UART_RX_PARITY_EN
        chk("parity_err_pulse", perr_total - p0, 1);
        chk("parity_err_no_byte", got_q.size(), 0);
`else
        exp_q = '{8'h81};
        chk_queue("post_reset", exp_q);
`endif

        // Randomised frames against a byte-level model, READY toggling randomly
        got_q.delete();
        exp_q.delete();
        f0 = ferr_total;
        exp_ferr = 0;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    READY = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join_none
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic bad;
            d = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad, 1'b0);
            if (bad) begin
                exp_ferr++;
                RS_RX = 1'b0;
                tick($urandom_range(0, 30));
                RS_RX = 1'b1;
                tick($urandom_range(4, 40));
            end else begin
                exp_q.push_back(d);
                RS_RX = 1'b1;
                tick($urandom_range(0, 40));
            end
        end
        rnd_on = 1'b0;
        tick(3);
        READY = 1'b1;
        tick(2 * CPB);
        chk("rand_frame_err", ferr_total - f0, exp_ferr);
        chk_queue("rand", exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
Serial receiver feeding the CPU top's program/data loader from the RS_RX pin. It runs at 8N1, LSB first, with an idle-high line. It synchronises and samples the line at mid-bit and reassembles bytes. Received bytes are queued in a small FIFO and presented on a valid/ready interface. This is the stage that turns the host's byte stream (e.g. 0x00,0x00,0x00,0x0A) into bytes for the loader.

Parameters:
CLKS_PER_BIT, 143, clock cycles per bit. 2000 ns bit time at 14 ns clock; must be >= 4.
FIFO_DEPTH, 4, byte entries in the output FIFO; power of two, >= 2.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
RS_RX  in  1  asynchronous serial input, idle high
DATA  out  8  byte at FIFO head; valid only while VALID=1
VALID  out  1  FIFO non-empty
READY  in  1  consumer accepts DATA when VALID&&READY at a CLK edge
FRAME_ERR  out  1  one-cycle pulse: stop bit sampled 0
OVERRUN  out  1  one-cycle pulse: byte completed while FIFO full and no pop that cycle

Behaviour:
- Reset values:
  - Synchroniser flops = 1; state = IDLE; counters = 0; FIFO empty.
  - VALID=0, DATA=0, FRAME_ERR=0, OVERRUN=0.
- Input synchroniser: two flops on RS_RX. All decisions use the second flop (rx_s).
- IDLE: rx_s==0 -> START; bit counter loaded with CLKS_PER_BIT/2 - 1 (integer division).
- START:
  - Counter expiry with rx_s==0 -> DATA; counter = CLKS_PER_BIT-1; bit index = 0.
  - Counter expiry with rx_s==1 -> glitch; return to IDLE; no output, no error.
- DATA:
  - Each expiry shifts rx_s into the shift register MSB side (LSB-first), then reloads the counter.
  - After the 8th sample -> STOP.
- STOP, at mid-bit expiry:
  - rx_s==1: push byte; -> IDLE immediately. Back-to-back frames are supported; the next start edge may arrive half a bit later.
  - rx_s==0: FRAME_ERR pulse; byte discarded; -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. A held-low line yields exactly one FRAME_ERR.
- FIFO:
  - Show-ahead: DATA is driven from the head entry, registered.
  - Pop on VALID&&READY.
  - Push latency: VALID rises the cycle after the stop-bit sample edge when the FIFO was empty.
  - Push with full and no pop: byte dropped, OVERRUN pulses, contents unchanged.
  - Push with full and simultaneous pop: both occur; no OVERRUN.
  - Push with empty and READY=1: no bypass. VALID appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is width clog2(FIFO_DEPTH)+1.
- RST asserted mid-frame: partial byte abandoned, FIFO flushed, back to IDLE next cycle. A frame in progress when RST deasserts is ignored until the line is seen low from IDLE. A low line at release is treated as a start.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1: a PARITY state sits between DATA and STOP.
  - Parity is sampled at mid-bit. Even parity over data plus parity bit is required.
  - Mismatch: byte discarded at STOP; output PARITY_ERR (1-bit) pulses one cycle, coincident with where the push would occur.
  - If the stop bit is also bad, only FRAME_ERR pulses.
- Undefined: no PARITY state, no PARITY_ERR port, 8N1 only.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the bits-per-frame constant;
  - the default baud divisor for the 14 ns clock, shared with a future uart_tx.
- Sub-module sync_fifo (WIDTH, DEPTH) with push/pop/full/empty/head ports, reusable by the transmitter.
- The receive FSM stays in uart_rx_buffered.

Test Plan (bench sets CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. After RST, idle line; send 0x0A (frame 0,0101_0000,1) with READY=1 -> VALID high for exactly 1 cycle with DATA=0x0A, no error pulses.
2. Back-to-back 0x00,0x00,0x00,0x0A with no idle gap, READY=1 -> four accepted bytes in that order.
3. RS_RX low for 4 cycles, then high -> no VALID, no FRAME_ERR; a following 0x55 is received correctly.
4. Frame 0x3C with stop bit 0, line held low 40 cycles, then high -> one FRAME_ERR pulse, no VALID; a subsequent 0xA5 is received.
5. READY=0, send 0x01..0x05 -> VALID stays high; one OVERRUN pulse at the 5th stop sample. Then READY=1 -> drains 0x01,0x02,0x03,0x04.
6. RST pulsed during data bit 3 of 0xFF -> VALID=0, FIFO empty. Next full 0x81 frame -> DATA=0x81.
   - With UART_RX_PARITY_EN defined: 0x81 sent with parity 1 -> PARITY_ERR pulse, no VALID.
